uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter among NUM_REQ byte producers using round-robin arbitration.
- Latches one byte from the winning requester and drives the transmitter's data_in/send pair, using the transmitter's busy output to sequence the frame.
- Sits between client logic and the transmitter port of uart_top; the receiver path is untouched.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
// The header-tag states and constant exist only when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

  localparam int CNT_W = 16;

`ifdef UART_ARB_TAG_EN
  localparam logic [7:0] TAG_BASE = 8'hA0;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    WAIT_HDR,
    SEND,
    WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;
`endif

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: first valid requester at or above rr_ptr,
// wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   winner
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     sum;

  // NOTE: every output gets a default before the loop so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    sum    = '0;
    rot    = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    // Walk from the farthest offset down so the nearest valid index wins last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
        if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
        winner = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_TAG_EN to prefix each payload with header byte 8'hA0 | grant_id.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65535,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_send,
  input  logic                 uart_busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 active,
  output logic                 timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           wait_next;
  logic [7:0]       byte_q;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [CNT_W-1:0] cnt;
  logic             pick_any;
  logic [IDX_W-1:0] pick_id;
  logic [7:0]       pick_byte;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any       (pick_any),
    .winner    (pick_id)
  );

  assign pick_byte = req_data[{pick_id, 3'b000} +: 8];
  assign next_ptr  = (pick_id == IDX_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
  assign active    = (state != IDLE);

  always_comb begin
    wait_next = WAIT;
`ifdef UART_ARB_TAG_EN
    if (state == SEND_HDR) wait_next = WAIT_HDR;
`endif
  end

`ifndef UART_ARB_TAG_EN
  assign uart_data = byte_q;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      byte_q      <= 8'h00;
      rr_ptr      <= '0;
      cnt         <= '0;
      req_ready   <= '0;
      uart_send   <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
`ifdef UART_ARB_TAG_EN
      uart_data   <= 8'h00;
`endif
    end else begin
      req_ready   <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            byte_q    <= pick_byte;
            grant_id  <= pick_id;
            rr_ptr    <= next_ptr;
            req_ready <= NUM_REQ'(1) << pick_id;
            cnt       <= '0;
            uart_send <= 1'b1;
`ifdef UART_ARB_TAG_EN
            uart_data <= TAG_BASE | 8'(pick_id);
            state     <= SEND_HDR;
`else
            state     <= SEND;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        SEND_HDR,
`endif
        SEND: begin
          if (uart_busy) begin
            uart_send <= 1'b0;
            state     <= wait_next;
          end else if (cnt == CNT_LAST) begin
            // Transmitter never acknowledged: drop the byte (and any payload).
            uart_send   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_ARB_TAG_EN
        WAIT_HDR: begin
          if (!uart_busy) begin
            uart_data <= byte_q;
            uart_send <= 1'b1;
            cnt       <= '0;
            state     <= SEND;
          end
        end
`endif
        WAIT: begin
          if (!uart_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios, a transmitter
// model, and a per-cycle scoreboard of grants and transmitted bytes.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N-1:0]           req_valid = '0;
  logic [8*N-1:0]         req_data = '0;
  logic [N-1:0]           req_ready;
  logic [7:0]             uart_data;
  logic                   uart_send;
  logic                   uart_busy = 1'b0;
  logic [$clog2(N)-1:0]   grant_id;
  logic                   active;
  logic                   timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  bit tx_en = 1'b1;

  int         m_ptr = 0;
  int         m_grant = 0;
  int         send_run = 0;
  int         to_cnt = 0;
  bit         prev_send = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  logic [N-1:0]   last_valid = '0;
  logic [8*N-1:0] last_data = '0;
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] exp_seq[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .uart_data   (uart_data),
    .uart_send   (uart_send),
    .uart_busy   (uart_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Bytes the transmitter must see for one grant of requester i carrying d.
  task automatic push_exp(input int i, input logic [7:0] d);
    if (TAG) exp_seq.push_back(8'hA0 | 8'(i));
    exp_seq.push_back(d);
  endtask

  // Transmitter: busy rises 3 cycles after send is seen and is held 10 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_en && rst_n && uart_send) begin
        repeat (3) @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // Scoreboard: round-robin winner, grant_id, byte order, timeout length.
  initial begin
    int w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0;
        m_grant = 0;
        prev_send = 1'b0;
        exp_q.delete();
      end else begin
        check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
        if (req_ready != '0) begin
          w = pick(last_valid, m_ptr);
          check("grant_ready", 32'(req_ready), (w < 0) ? 0 : (1 << w));
          if (w >= 0) begin
            m_grant = w;
            m_ptr = (w + 1) % N;
            if (TAG) exp_q.push_back(8'hA0 | 8'(w));
            exp_q.push_back(last_data[8*w +: 8]);
          end
        end
        check("grant_id", 32'(grant_id), m_grant);
        if (uart_send) check("send_active", 32'(active), 1);
        if (uart_send && !prev_send) begin
          sent_q.push_back(uart_data);
          cur_byte = uart_data;
          send_run = 0;
          check("tx_pending", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("tx_byte", 32'(uart_data), 32'(exp_q.pop_front()));
        end
        if (uart_send) begin
          check("tx_stable", 32'(uart_data), 32'(cur_byte));
          send_run++;
        end
        if (timeout_err) begin
          to_cnt++;
          check("timeout_len", send_run, TO);
          check("timeout_idle", 32'(active), 0);
          exp_q.delete();
        end
        prev_send = uart_send;
      end
      last_valid = req_valid;
      last_data = req_data;
    end
  end

  task automatic wait_grant(input string name, output int id);
    bit found;
    found = 1'b0;
    id = -1;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        found = 1'b1;
        for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
      end
    end
    check({name, "_granted"}, 32'(found), 1);
  endtask

  task automatic wait_idle(input string name);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (!active) found = 1'b1;
    end
    check({name, "_idle"}, 32'(found), 1);
  endtask

  task automatic set_req(input int i, input logic [7:0] d);
    req_data[8*i +: 8] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic drop(input int i);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  initial begin
    int id, ov, base, cyc, to_base;
    bit seen;
    int order[5] = '{0, 1, 2, 3, 0};

    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_send", 32'(uart_send), 0);
    check("rst_data", 32'(uart_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_active", 32'(active), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Contention: all four valid continuously.
    base = sent_q.size();
    exp_seq.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) set_req(i, 8'h10 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      wait_grant("cont", id);
      check("cont_order", id, order[k]);
      push_exp(order[k], 8'h10 + 8'(order[k]));
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle("cont");
    check("cont_nsent", sent_q.size() - base, exp_seq.size());
    for (int k = 0; k < exp_seq.size() && base + k < sent_q.size(); k++)
      check("cont_bytes", 32'(sent_q[base + k]), 32'(exp_seq[k]));

    // Single request from requester 1.
    @(posedge clk);
    #1 set_req(1, 8'h55);
    wait_grant("single", id);
    check("single_id", id, 1);
    check("single_ready", 32'(req_ready), 32'h2);
    check("single_grant_id", 32'(grant_id), 1);
    check("single_data", 32'(uart_data), TAG ? 32'hA1 : 32'h55);
    check("single_send", 32'(uart_send), 1);
    drop(1);
    @(negedge clk);
    check("single_ready_pulse", 32'(req_ready), 0);
    ov = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (uart_send && uart_busy) ov++;
      if (!active) seen = 1'b1;
    end
    check("single_idle", 32'(seen), 1);
    check("single_overlap", ov, TAG ? 2 : 1);
    check("single_send_len", send_run, 4);
    check("single_busy_low", 32'(uart_busy), 0);
    check("single_last_grant", 32'(grant_id), 1);
    check("single_last_byte", 32'(sent_q[$]), 32'h55);

    // Wrap: grant 2 (pointer moves to 3), then 0 beats 2.
    @(posedge clk);
    #1 set_req(2, 8'h22);
    wait_grant("wrap_a", id);
    check("wrap_first", id, 2);
    drop(2);
    wait_idle("wrap_a");
    @(posedge clk);
    #1;
    set_req(0, 8'h5A);
    set_req(2, 8'h22);
    wait_grant("wrap_b", id);
    check("wrap_id", id, 0);
    drop(0);
    wait_grant("wrap_c", id);
    check("wrap_next", id, 2);
    drop(2);
    wait_idle("wrap_c");
    check("wrap_last_byte", 32'(sent_q[$]), 32'h22);

    // Timeout: transmitter silent for requester 1, then requester 2 serviced.
    to_base = to_cnt;
    tx_en = 1'b0;
    @(posedge clk);
    #1;
    set_req(1, 8'hC1);
    set_req(2, 8'hC2);
    wait_grant("to_a", id);
    check("to_first", id, 1);
    drop(1);
    cyc = 1;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (timeout_err) seen = 1'b1;
      else if (uart_send) cyc++;
    end
    check("to_seen", 32'(seen), 1);
    check("to_send_cycles", cyc, TO);
    tx_en = 1'b1;
    wait_grant("to_b", id);
    check("to_next", id, 2);
    drop(2);
    wait_idle("to_b");
    check("to_count", to_cnt - to_base, 1);
    check("to_last_byte", 32'(sent_q[$]), 32'hC2);

    // Reset while waiting for the transmitter to finish.
    @(posedge clk);
    #1 set_req(3, 8'h33);
    wait_grant("rst_a", id);
    check("rst_pre_id", id, 3);
    drop(3);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (uart_busy && !uart_send) seen = 1'b1;
    end
    check("rst_in_wait", 32'(seen), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_send", 32'(uart_send), 0);
    check("mid_rst_data", 32'(uart_data), 0);
    check("mid_rst_grant_id", 32'(grant_id), 0);
    check("mid_rst_active", 32'(active), 0);
    check("mid_rst_timeout", 32'(timeout_err), 0);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (!uart_busy) seen = 1'b1;
    end
    check("rst_busy_done", 32'(seen), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) set_req(i, 8'h10 + 8'(i));
    wait_grant("rst_b", id);
    check("rst_post_id", id, 0);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle("rst_b");
    check("rst_post_byte", 32'(sent_q[$]), 32'h10);

    check("exp_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
